// File: rtl/instruction_cache.sv
// instruction_cache: direct-mapped, read-only instruction cache.
// Each line holds a 16-byte (4-word) block. A hit is served combinationally in
// the same cycle. A miss stalls the CPU through BUSYWAIT, fetches the block
// from the slow instruction memory, installs it and then serves the fetch.
// Optional feature macro: ICACHE_STATS_EN adds saturating HIT_COUNT/MISS_COUNT.
// NUM_BLOCKS is assumed to be a power of two and at least 2.

module instruction_cache #(
    parameter int NUM_BLOCKS = 8,
    parameter int ADDR_W     = 10
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [ADDR_W-1:0] ADDRESS,
    output logic [31:0]       READINST,
    output logic              BUSYWAIT,
    output logic              MEM_READ,
    output logic [ADDR_W-5:0] MEM_ADDRESS,
    input  logic [127:0]      MEM_READINST,
    input  logic              MEM_BUSYWAIT
`ifdef ICACHE_STATS_EN
    ,
    output logic [15:0]       HIT_COUNT,
    output logic [15:0]       MISS_COUNT
`endif
);

    localparam int IDX_W = $clog2(NUM_BLOCKS);
    localparam int BA_W  = ADDR_W - 4;
    localparam int TAG_W = BA_W - IDX_W;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_UPDATE = 2'd2
    } state_e;

    // Control state
    state_e                  state_q;
    state_e                  state_d;
    logic [BA_W-1:0]         miss_addr_q;
    logic [BA_W-1:0]         miss_addr_d;
    logic [NUM_BLOCKS-1:0]   valid_q;
    logic [NUM_BLOCKS-1:0]   valid_d;

    // Line storage (never cleared; valid bits gate its use)
    logic [TAG_W-1:0]        tag_q  [NUM_BLOCKS];
    logic [TAG_W-1:0]        tag_d  [NUM_BLOCKS];
    logic [127:0]            data_q [NUM_BLOCKS];
    logic [127:0]            data_d [NUM_BLOCKS];

    // Address decomposition and lookup
    logic [IDX_W-1:0]        idx_s;
    logic [TAG_W-1:0]        tag_s;
    logic [1:0]              off_s;
    logic [IDX_W-1:0]        miss_idx_s;
    logic [TAG_W-1:0]        miss_tag_s;
    logic [127:0]            line_s;
    logic                    hit_s;
    logic                    fill_s;
    logic                    unused_addr_s;

    assign idx_s         = ADDRESS[3+IDX_W:4];
    assign tag_s         = ADDRESS[ADDR_W-1:4+IDX_W];
    assign off_s         = ADDRESS[3:2];
    assign miss_idx_s    = miss_addr_q[IDX_W-1:0];
    assign miss_tag_s    = miss_addr_q[BA_W-1:IDX_W];
    assign unused_addr_s = ^ADDRESS[1:0];

    // Combinational tag compare and line read for the current fetch address
    always_comb begin
        line_s = data_q[idx_s];
        hit_s  = valid_q[idx_s] && (tag_q[idx_s] == tag_s);
    end

    // Word select inside the addressed line
    always_comb begin
        case (off_s)
            2'd0:    READINST = line_s[31:0];
            2'd1:    READINST = line_s[63:32];
            2'd2:    READINST = line_s[95:64];
            2'd3:    READINST = line_s[127:96];
            default: READINST = line_s[31:0];
        endcase
    end

    // Next-state logic: miss detection, refill completion, settle cycle
    always_comb begin
        state_d     = state_q;
        miss_addr_d = miss_addr_q;
        fill_s      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!hit_s) begin
                    state_d     = ST_FETCH;
                    miss_addr_d = {tag_s, idx_s};
                end else begin
                    state_d     = ST_IDLE;
                end
            end
            ST_FETCH: begin
                // A response arriving while RESET is high is discarded
                if (!MEM_BUSYWAIT && !RESET) begin
                    state_d = ST_UPDATE;
                    fill_s  = 1'b1;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_UPDATE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Line-array update on refill; only the missing line changes
    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (fill_s) begin
            valid_d[miss_idx_s] = 1'b1;
            tag_d[miss_idx_s]   = miss_tag_s;
            data_d[miss_idx_s]  = MEM_READINST;
        end else begin
            valid_d = valid_q;
        end
    end

    // Output decode: stall request and memory handshake
    always_comb begin
        MEM_READ    = (state_q == ST_FETCH);
        MEM_ADDRESS = miss_addr_q;
        if (RESET) begin
            BUSYWAIT = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE:   BUSYWAIT = !hit_s;
                ST_FETCH:  BUSYWAIT = 1'b1;
                ST_UPDATE: BUSYWAIT = 1'b1;
                default:   BUSYWAIT = 1'b1;
            endcase
        end
    end

    // State register with synchronous reset of control state and valid bits
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= ST_IDLE;
            miss_addr_q <= '0;
            valid_q     <= '0;
        end else begin
            state_q     <= state_d;
            miss_addr_q <= miss_addr_d;
            valid_q     <= valid_d;
        end
    end

    // Tag and data arrays keep their contents across reset
    always_ff @(posedge CLK) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

`ifdef ICACHE_STATS_EN
    logic [15:0] hit_cnt_q;
    logic [15:0] hit_cnt_d;
    logic [15:0] miss_cnt_q;
    logic [15:0] miss_cnt_d;

    // Saturating hit/miss counters, sampled on IDLE cycles only
    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (state_q == ST_IDLE) begin
            if (hit_s) begin
                if (hit_cnt_q != 16'hFFFF) begin
                    hit_cnt_d = hit_cnt_q + 16'd1;
                end else begin
                    hit_cnt_d = hit_cnt_q;
                end
            end else begin
                if (miss_cnt_q != 16'hFFFF) begin
                    miss_cnt_d = miss_cnt_q + 16'd1;
                end else begin
                    miss_cnt_d = miss_cnt_q;
                end
            end
        end else begin
            hit_cnt_d  = hit_cnt_q;
            miss_cnt_d = miss_cnt_q;
        end
    end

    // Counter registers, cleared by reset
    always_ff @(posedge CLK) begin
        if (RESET) begin
            hit_cnt_q  <= 16'd0;
            miss_cnt_q <= 16'd0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign HIT_COUNT  = hit_cnt_q;
    assign MISS_COUNT = miss_cnt_q;
`endif

endmodule

// File: tb/tb_instruction_cache.sv
// Directed testbench for instruction_cache (default parameters).
// Inputs are driven just after the falling edge and outputs sampled 1 ns later.

module tb_instruction_cache;

    logic         CLK;
    logic         RESET;
    logic [9:0]   ADDRESS;
    logic [31:0]  READINST;
    logic         BUSYWAIT;
    logic         MEM_READ;
    logic [5:0]   MEM_ADDRESS;
    logic [127:0] MEM_READINST;
    logic         MEM_BUSYWAIT;
`ifdef ICACHE_STATS_EN
    logic [15:0]  HIT_COUNT;
    logic [15:0]  MISS_COUNT;
`endif

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] JUNK = 128'hDEAD_BEEF_0BAD_F00D_DEAD_BEEF_0BAD_F00D;

    instruction_cache dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .ADDRESS      (ADDRESS),
        .READINST     (READINST),
        .BUSYWAIT     (BUSYWAIT),
        .MEM_READ     (MEM_READ),
        .MEM_ADDRESS  (MEM_ADDRESS),
        .MEM_READINST (MEM_READINST),
        .MEM_BUSYWAIT (MEM_BUSYWAIT)
`ifdef ICACHE_STATS_EN
        ,
        .HIT_COUNT    (HIT_COUNT),
        .MISS_COUNT   (MISS_COUNT)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Word w of the memory block at block address ba
    function automatic logic [31:0] word_of(input logic [5:0] ba, input int w);
        logic [1:0] w2;
        w2 = w[1:0];
        word_of = {16'hCA00 + {10'd0, ba}, 14'd0, w2};
    endfunction

    function automatic logic [127:0] mk_block(input logic [5:0] ba);
        mk_block = {word_of(ba, 3), word_of(ba, 2), word_of(ba, 1), word_of(ba, 0)};
    endfunction

    task automatic set_addr(input logic [9:0] a);
        @(negedge CLK);
        ADDRESS = a;
        #1;
    endtask

    // Runs a refill that starts in the current (IDLE-detect) cycle; returns the
    // number of stall cycles before the next IDLE cycle and BUSYWAIT in that cycle.
    task automatic run_miss(input string nm, input logic [5:0] exp_ma, input int busy,
                            input bit sw_en, input logic [9:0] sw_addr,
                            output int bw_cycles, output logic bw_idle);
        int rd;
        bit upd;
        bit done;
        rd = 0; upd = 0; done = 0; bw_cycles = 0; bw_idle = 1'bx;
        checks++;
        if (BUSYWAIT !== 1'b1 || MEM_READ !== 1'b0) begin
            errors++;
            $display("FAIL %s_detect: BUSYWAIT=%b MEM_READ=%b required 1/0", nm, BUSYWAIT, MEM_READ);
        end
        for (int k = 0; k < 64 && !done; k++) begin
            if (k > 0) begin
                @(negedge CLK);
                #1;
            end
            if (upd) begin
                done    = 1;
                bw_idle = BUSYWAIT;
            end else begin
                if (BUSYWAIT === 1'b1) bw_cycles++;
                if (MEM_READ === 1'b1) begin
                    rd++;
                    checks++;
                    if (MEM_ADDRESS !== exp_ma) begin
                        errors++;
                        $display("FAIL %s_mem_addr: got %h required %h", nm, MEM_ADDRESS, exp_ma);
                    end
                    if (sw_en && rd == 2) ADDRESS = sw_addr;
                    if (rd <= busy) begin
                        MEM_BUSYWAIT = 1'b1;
                        MEM_READINST = JUNK;
                    end else begin
                        MEM_BUSYWAIT = 1'b0;
                        MEM_READINST = mk_block(exp_ma);
                    end
                end else begin
                    if (rd > 0) upd = 1;
                    MEM_BUSYWAIT = 1'b0;
                    MEM_READINST = JUNK;
                end
            end
        end
        checks++;
        if (!done || rd != busy + 1) begin
            errors++;
            $display("FAIL %s_fetch_len: done=%0d read_cycles=%0d required %0d", nm, done, rd, busy + 1);
        end
    endtask

    task automatic check_refill(input string nm, input int bw, input logic bwi,
                                input int exp_bw, input logic exp_bwi);
        checks++;
        if (bw != exp_bw || bwi !== exp_bwi) begin
            errors++;
            $display("FAIL %s_latency: stall=%0d idle_busy=%b required %0d/%b", nm, bw, bwi, exp_bw, exp_bwi);
        end
    endtask

    task automatic test_reset();
        RESET = 1'b1; ADDRESS = 10'h000; MEM_BUSYWAIT = 1'b0; MEM_READINST = 128'd0;
        repeat (2) @(posedge CLK);
        #1;
        checks++;
        if (BUSYWAIT !== 1'b0 || MEM_READ !== 1'b0 || MEM_ADDRESS !== 6'h00) begin
            errors++;
            $display("FAIL reset_outputs: BUSYWAIT=%b MEM_READ=%b MEM_ADDRESS=%h required 0/0/00",
                     BUSYWAIT, MEM_READ, MEM_ADDRESS);
        end
`ifdef ICACHE_STATS_EN
        checks++;
        if (HIT_COUNT !== 16'd0 || MISS_COUNT !== 16'd0) begin
            errors++;
            $display("FAIL reset_counts: hit=%0d miss=%0d required 0/0", HIT_COUNT, MISS_COUNT);
        end
`endif
        @(negedge CLK);
        RESET = 1'b0;
        #1;
    endtask

    task automatic test_first_miss();
        int bw;
        logic bwi;
        run_miss("first", 6'h00, 4, 1'b0, 10'h000, bw, bwi);
        check_refill("first", bw, bwi, 7, 1'b0);
        checks++;
        if (READINST !== word_of(6'h00, 0) || MEM_READ !== 1'b0) begin
            errors++;
            $display("FAIL first_word0: got %h mem_read=%b required %h/0", READINST, MEM_READ, word_of(6'h00, 0));
        end
    endtask

    task automatic test_hits();
        for (int i = 1; i < 4; i++) begin
            set_addr(10'(i * 4));
            checks++;
            if (BUSYWAIT !== 1'b0 || MEM_READ !== 1'b0 || READINST !== word_of(6'h00, i)) begin
                errors++;
                $display("FAIL hit_word%0d: busy=%b mem_read=%b inst=%h required 0/0/%h",
                         i, BUSYWAIT, MEM_READ, READINST, word_of(6'h00, i));
            end
        end
    endtask

    task automatic test_eviction();
        int bw;
        logic bwi;
        set_addr(10'h080);
        run_miss("evict", 6'h08, 2, 1'b0, 10'h000, bw, bwi);
        check_refill("evict", bw, bwi, 5, 1'b0);
        checks++;
        if (READINST !== word_of(6'h08, 0)) begin
            errors++;
            $display("FAIL evict_word0: got %h required %h", READINST, word_of(6'h08, 0));
        end
        set_addr(10'h000);
        run_miss("refetch", 6'h00, 0, 1'b0, 10'h000, bw, bwi);
        check_refill("refetch", bw, bwi, 3, 1'b0);
        checks++;
        if (READINST !== word_of(6'h00, 0)) begin
            errors++;
            $display("FAIL refetch_word0: got %h required %h", READINST, word_of(6'h00, 0));
        end
`ifdef ICACHE_STATS_EN
        checks++;
        if (HIT_COUNT !== 16'd5 || MISS_COUNT !== 16'd3) begin
            errors++;
            $display("FAIL stats_after_three: hit=%0d miss=%0d required 5/3", HIT_COUNT, MISS_COUNT);
        end
`endif
    endtask

    task automatic test_addr_change();
        int bw;
        logic bwi;
        set_addr(10'h3FC);
        run_miss("switch", 6'h3F, 3, 1'b1, 10'h010, bw, bwi);
        check_refill("switch", bw, bwi, 6, 1'b1);
        run_miss("after_switch", 6'h01, 1, 1'b0, 10'h000, bw, bwi);
        check_refill("after_switch", bw, bwi, 4, 1'b0);
        checks++;
        if (READINST !== word_of(6'h01, 0)) begin
            errors++;
            $display("FAIL after_switch_word0: got %h required %h", READINST, word_of(6'h01, 0));
        end
        set_addr(10'h3FC);
        checks++;
        if (BUSYWAIT !== 1'b0 || READINST !== word_of(6'h3F, 3)) begin
            errors++;
            $display("FAIL wrap_hit: busy=%b inst=%h required 0/%h", BUSYWAIT, READINST, word_of(6'h3F, 3));
        end
    endtask

    task automatic test_reset_mid_fetch();
        int bw;
        logic bwi;
        set_addr(10'h040);
        MEM_BUSYWAIT = 1'b1;
        @(negedge CLK);
        #1;
        checks++;
        if (MEM_READ !== 1'b1 || MEM_ADDRESS !== 6'h04) begin
            errors++;
            $display("FAIL rst_fetch_start: mem_read=%b addr=%h required 1/04", MEM_READ, MEM_ADDRESS);
        end
        @(negedge CLK);
        RESET = 1'b1;
        #1;
        checks++;
        if (BUSYWAIT !== 1'b0) begin
            errors++;
            $display("FAIL rst_busywait: got %b required 0", BUSYWAIT);
        end
        @(posedge CLK);
        #1;
        checks++;
        if (MEM_READ !== 1'b0 || MEM_ADDRESS !== 6'h00) begin
            errors++;
            $display("FAIL rst_mem_read: mem_read=%b addr=%h required 0/00", MEM_READ, MEM_ADDRESS);
        end
`ifdef ICACHE_STATS_EN
        checks++;
        if (HIT_COUNT !== 16'd0 || MISS_COUNT !== 16'd0) begin
            errors++;
            $display("FAIL rst_counts: hit=%0d miss=%0d required 0/0", HIT_COUNT, MISS_COUNT);
        end
`endif
        @(negedge CLK);
        RESET = 1'b0;
        ADDRESS = 10'h000;
        MEM_BUSYWAIT = 1'b0;
        MEM_READINST = mk_block(6'h04);
        #1;
        run_miss("post_rst", 6'h00, 1, 1'b0, 10'h000, bw, bwi);
        check_refill("post_rst", bw, bwi, 4, 1'b0);
        set_addr(10'h040);
        run_miss("late_drop", 6'h04, 0, 1'b0, 10'h000, bw, bwi);
        check_refill("late_drop", bw, bwi, 3, 1'b0);
        checks++;
        if (READINST !== word_of(6'h04, 0)) begin
            errors++;
            $display("FAIL late_drop_word0: got %h required %h", READINST, word_of(6'h04, 0));
        end
    endtask

    task automatic test_stats_saturate();
`ifdef ICACHE_STATS_EN
        set_addr(10'h004);
        repeat (70000) @(posedge CLK);
        #1;
        checks++;
        if (HIT_COUNT !== 16'hFFFF) begin
            errors++;
            $display("FAIL hit_saturate: got %h required ffff", HIT_COUNT);
        end
`else
        set_addr(10'h004);
`endif
    endtask

    initial begin
        test_reset();
        test_first_miss();
        test_hits();
        test_eviction();
        test_addr_change();
        test_reset_mid_fetch();
        test_stats_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
